bpsk_modulator: RTL and testbench

Downstream neighbour of the transmit buffer inside `satcom`: accepts the 1200 b/s serial telemetry stream one bit at a time over a dav/ack handshake, optionally differentially encodes it, and produces a BPSK-modulated audio-band carrier as 16-bit offset-binary samples on `dac_sample`. It runs entirely in the 100 MHz domain and generates its own fixed DAC sample rate. Its output replaces the current `dac_sample` waveform testpoint.

---
 rtl/bpsk_modulator_pkg.sv | 20 ++
 rtl/bpsk_modulator_if.sv | 19 +
 rtl/bpsk_modulator_sine_lut.sv | 39 +++
 rtl/bpsk_modulator.sv | 130 +++++++++++++
 tb/tb_bpsk_modulator.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bpsk_modulator_pkg.sv
// Shared constants and types for the BPSK telemetry modulator.
// Holds the FSM encoding, DAC midscale, sine table geometry and the offset-binary conversion.
package bpsk_modulator_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [15:0] DAC_MIDSCALE    = 16'h8000;
  localparam int          SINE_PHASE_BITS = 6;
  localparam int          SINE_AMPL       = 32767;
  localparam int          PHASE_STEPS     = 1 << SINE_PHASE_BITS;

  // Adding midscale only flips the MSB, so the wrap modulo 2^16 is free.
  function automatic logic [15:0] to_offset_binary(input logic signed [15:0] s);
    return $unsigned(s) + DAC_MIDSCALE;
  endfunction

endpackage

// File: rtl/bpsk_modulator_if.sv
// Bit-serial dav/ack handshake between the transmit buffer and the modulator.
// The upstream side holds bit_in and dav until it sees a one-cycle ack.
interface bpsk_modulator_if;
  logic bit_in;
  logic dav;
  logic ack;

  modport master (
    output bit_in,
    output dav,
    input  ack
  );

  modport slave (
    input  bit_in,
    input  dav,
    output ack
  );
endinterface

// File: rtl/bpsk_modulator_sine_lut.sv
// Combinational 64-point sine built from a 17-entry quarter-wave table.
// Amplitude is symmetric (+/-32767) so the caller can negate without overflow.
module bpsk_sine_lut
  import bpsk_modulator_pkg::*;
(
  input  logic [SINE_PHASE_BITS-1:0] phase,
  output logic signed [15:0]         sample
);

  logic [4:0]  q_idx;
  logic [15:0] mag;

  always_comb begin
    q_idx = phase[SINE_PHASE_BITS-2] ? (5'd16 - {1'b0, phase[3:0]})
                                     : {1'b0, phase[3:0]};
    case (q_idx)
      5'd0:    mag = 16'd0;
      5'd1:    mag = 16'd3212;
      5'd2:    mag = 16'd6393;
      5'd3:    mag = 16'd9512;
      5'd4:    mag = 16'd12539;
      5'd5:    mag = 16'd15446;
      5'd6:    mag = 16'd18204;
      5'd7:    mag = 16'd20787;
      5'd8:    mag = 16'd23170;
      5'd9:    mag = 16'd25329;
      5'd10:   mag = 16'd27245;
      5'd11:   mag = 16'd28898;
      5'd12:   mag = 16'd30273;
      5'd13:   mag = 16'd31356;
      5'd14:   mag = 16'd32137;
      5'd15:   mag = 16'd32609;
      5'd16:   mag = 16'(SINE_AMPL);
      default: mag = 16'd0;
    endcase
    sample = phase[SINE_PHASE_BITS-1] ? -$signed(mag) : $signed(mag);
  end

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK modulator: serial bits in over dav/ack, offset-binary carrier samples out at a fixed DAC rate.
//   state   | meaning
//   ST_IDLE | no bit in flight; emits midscale, waits for dav on a strobe
//   ST_RUN  | modulating the current symbol, one sample per strobe
module bpsk_modulator
  import bpsk_modulator_pkg::*;
#(
  parameter int SAMPLE_DIV      = 1302,
  parameter int SAMPLES_PER_BIT = 64,
  parameter int CARRIER_STEP    = 2,
  parameter bit DIFF_ENC        = 1'b1
) (
  input  logic                   clk_100M,
  input  logic                   rst,
  bpsk_modulator_if.slave        bus,
  output logic [15:0]            dac_sample,
  output logic                   sample_stb,
  output logic                   busy,
  output logic                   underrun
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int K_W   = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam logic [DIV_W-1:0]           DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [K_W-1:0]             K_LAST    = K_W'(SAMPLES_PER_BIT - 1);
  localparam logic [SINE_PHASE_BITS-1:0] PHASE_INC = SINE_PHASE_BITS'(CARRIER_STEP);

  // A bit must span whole carrier cycles so every bit starts back at phase 0.
  if ((SAMPLES_PER_BIT * CARRIER_STEP) % PHASE_STEPS != 0) begin : g_bad_step
    $error("SAMPLES_PER_BIT*CARRIER_STEP must be a multiple of %0d", PHASE_STEPS);
  end

  state_t                     state;
  logic [DIV_W-1:0]           div_cnt;
  logic [K_W-1:0]             k;
  logic [SINE_PHASE_BITS-1:0] phase;
  logic                       sym_q;
  logic                       ack_q;

  logic                       strobe;
  logic                       at_boundary;
  logic                       load_bit;
  logic                       new_sym;
  logic                       sym_use;
  logic [SINE_PHASE_BITS-1:0] phase_next;
  logic signed [15:0]         lut_val;
  logic signed [15:0]         sym_val;
  logic [15:0]                sample_next;

  assign bus.ack = ack_q;

  bpsk_sine_lut u_lut (
    .phase  (phase_next),
    .sample (lut_val)
  );

  always_comb begin
    strobe      = (div_cnt == DIV_LAST);
    at_boundary = (state == ST_IDLE) || (k == K_LAST);
    load_bit    = strobe && at_boundary && bus.dav;
    // sym_q holds the previous symbol and is zero whenever the FSM is idle.
    new_sym     = DIFF_ENC ? (sym_q ^ bus.bit_in) : bus.bit_in;
    phase_next  = (state == ST_IDLE) ? '0 : phase + PHASE_INC;
    sym_use     = load_bit ? new_sym : sym_q;
    sym_val     = sym_use ? -lut_val : lut_val;
    sample_next = to_offset_binary(sym_val);
  end

  always_ff @(posedge clk_100M) begin
    if (!rst) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      k          <= '0;
      phase      <= '0;
      sym_q      <= 1'b0;
      ack_q      <= 1'b0;
      dac_sample <= DAC_MIDSCALE;
      sample_stb <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      ack_q      <= 1'b0;
      sample_stb <= 1'b0;
      underrun   <= 1'b0;
      div_cnt    <= strobe ? '0 : div_cnt + 1'b1;

      if (strobe) begin
        sample_stb <= 1'b1;
        case (state)
          ST_IDLE: begin
            if (load_bit) begin
              sym_q      <= new_sym;
              ack_q      <= 1'b1;
              phase      <= '0;
              k          <= '0;
              dac_sample <= sample_next;
              busy       <= 1'b1;
              state      <= ST_RUN;
            end else begin
              dac_sample <= DAC_MIDSCALE;
            end
          end
          ST_RUN: begin
            if (!at_boundary) begin
              k          <= k + 1'b1;
              phase      <= phase_next;
              dac_sample <= sample_next;
            end else if (load_bit) begin
              sym_q      <= new_sym;
              ack_q      <= 1'b1;
              k          <= '0;
              phase      <= phase_next;
              dac_sample <= sample_next;
            end else begin
              sym_q      <= 1'b0;
              k          <= '0;
              phase      <= '0;
              dac_sample <= DAC_MIDSCALE;
              underrun   <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bpsk_modulator.sv
// Directed bench: two modulators (plain and differential) driven with identical stimulus.
// Expected samples are hand-computed from the quarter-wave table and the symbol rules.
module tb_bpsk_modulator;

  localparam int DIV  = 4;
  localparam int SPB  = 64;
  localparam int STEP = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bpsk_modulator_if bus0 ();
  bpsk_modulator_if bus1 ();

  logic [15:0] dac0, dac1;
  logic        stb0, stb1, busy0, busy1, und0, und1;

  bpsk_modulator #(.SAMPLE_DIV(DIV), .SAMPLES_PER_BIT(SPB), .CARRIER_STEP(STEP), .DIFF_ENC(1'b0)) dut0 (
    .clk_100M(clk), .rst(rst), .bus(bus0),
    .dac_sample(dac0), .sample_stb(stb0), .busy(busy0), .underrun(und0)
  );

  bpsk_modulator #(.SAMPLE_DIV(DIV), .SAMPLES_PER_BIT(SPB), .CARRIER_STEP(STEP), .DIFF_ENC(1'b1)) dut1 (
    .clk_100M(clk), .rst(rst), .bus(bus1),
    .dac_sample(dac1), .sample_stb(stb1), .busy(busy1), .underrun(und1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_ack0 = 0, n_ack1 = 0, n_und0 = 0, n_und1 = 0;

  task automatic drive(input logic b, input logic d);
    bus0.bit_in = b; bus0.dav = d;
    bus1.bit_in = b; bus1.dav = d;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus0.ack) n_ack0++;
    if (bus1.ack) n_ack1++;
    if (und0) n_und0++;
    if (und1) n_und1++;
  endtask

  task automatic step_samples(input int n);
    repeat (n * DIV) tick();
  endtask

  task automatic wait_ack(input int limit, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus0.ack && lat < limit);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0);
    repeat (10) tick();
    checks++;
    if ({dac0, dac1} !== {16'h8000, 16'h8000}) begin
      errors++; $display("FAIL reset_dac: got %h/%h expected 8000/8000", dac0, dac1);
    end
    checks++;
    if ({bus0.ack, bus1.ack, busy0, busy1, und0, und1, stb0, stb1} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags: got ack=%b%b busy=%b%b und=%b%b stb=%b%b expected all 0",
               bus0.ack, bus1.ack, busy0, busy1, und0, und1, stb0, stb1);
    end
    rst = 1'b1;
    for (int i = 1; i <= DIV; i++) begin
      tick();
      checks++;
      if ({stb0, stb1} !== ((i == DIV) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL first_strobe cycle %0d: got %b%b expected %b", i, stb0, stb1, i == DIV);
      end
    end
  endtask

  task automatic test_single_bit(input logic b, input logic [15:0] e4, input logic [15:0] e8,
                                 input logic [15:0] e24);
    int lat;
    int a0;
    drive(b, 1'b1);
    wait_ack(2 * DIV, lat);
    checks++;
    if ({bus0.ack, bus1.ack, stb0, stb1, busy0, busy1} !== 6'b111111) begin
      errors++;
      $display("FAIL single%0b_accept: got ack=%b%b stb=%b%b busy=%b%b expected all 1",
               b, bus0.ack, bus1.ack, stb0, stb1, busy0, busy1);
    end
    checks++;
    if (lat > DIV) begin
      errors++; $display("FAIL single%0b_latency: got %0d cycles expected <= %0d", b, lat, DIV);
    end
    checks++;
    if ({dac0, dac1} !== {16'h8000, 16'h8000}) begin
      errors++; $display("FAIL single%0b_k0: got %h/%h expected 8000", b, dac0, dac1);
    end
    drive(b, 1'b0);
    a0 = n_ack0 + n_ack1;
    step_samples(4);
    checks++;
    if ({dac0, dac1} !== {e4, e4}) begin
      errors++; $display("FAIL single%0b_k4: got %h/%h expected %h", b, dac0, dac1, e4);
    end
    step_samples(4);
    checks++;
    if ({dac0, dac1} !== {e8, e8}) begin
      errors++; $display("FAIL single%0b_k8: got %h/%h expected %h", b, dac0, dac1, e8);
    end
    step_samples(16);
    checks++;
    if ({dac0, dac1} !== {e24, e24}) begin
      errors++; $display("FAIL single%0b_k24: got %h/%h expected %h", b, dac0, dac1, e24);
    end
    step_samples(39);
    checks++;
    if ({busy0, busy1, und0, und1} !== 4'b1100) begin
      errors++; $display("FAIL single%0b_k63: got busy=%b%b und=%b%b expected busy=11 und=00",
                         b, busy0, busy1, und0, und1);
    end
    step_samples(1);
    checks++;
    if ({und0, und1, busy0, busy1, stb0, stb1} !== 6'b110011) begin
      errors++; $display("FAIL single%0b_underrun: got und=%b%b busy=%b%b stb=%b%b expected 11/00/11",
                         b, und0, und1, busy0, busy1, stb0, stb1);
    end
    checks++;
    if ({dac0, dac1} !== {16'h8000, 16'h8000}) begin
      errors++; $display("FAIL single%0b_end_dac: got %h/%h expected 8000", b, dac0, dac1);
    end
    checks++;
    if (n_ack0 + n_ack1 !== a0) begin
      errors++; $display("FAIL single%0b_extra_ack: got %0d acks expected %0d", b, n_ack0 + n_ack1, a0);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  bits;
    logic [15:0] exp0 [3];
    logic [15:0] exp1 [3];
    int lat, last_ack, a0, a1, u0, u1;
    bits = 3'b011;
    exp0 = '{16'h0001, 16'h0001, 16'hFFFF};
    exp1 = '{16'h0001, 16'hFFFF, 16'hFFFF};
    a0 = n_ack0; a1 = n_ack1; u0 = n_und0; u1 = n_und1;
    drive(bits[0], 1'b1);
    wait_ack(2 * DIV, lat);
    last_ack = cyc;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        step_samples(1);
        checks++;
        if ({bus0.ack, bus1.ack} !== 2'b11 || cyc - last_ack != DIV * SPB) begin
          errors++; $display("FAIL b2b_ack%0d: got ack=%b%b after %0d cycles expected 11 after %0d",
                             i, bus0.ack, bus1.ack, cyc - last_ack, DIV * SPB);
        end
        last_ack = cyc;
      end
      if (i < 2) drive(bits[i+1], 1'b1);
      else       drive(1'b0, 1'b0);
      step_samples(8);
      checks++;
      if ({dac0, dac1} !== {exp0[i], exp1[i]}) begin
        errors++; $display("FAIL b2b_k8_bit%0d: got %h/%h expected %h/%h", i, dac0, dac1, exp0[i], exp1[i]);
      end
      step_samples(55);
    end
    checks++;
    if (n_und0 != u0 || n_und1 != u1) begin
      errors++; $display("FAIL b2b_no_underrun: got %0d/%0d underruns expected 0", n_und0 - u0, n_und1 - u1);
    end
    step_samples(1);
    checks++;
    if (n_ack0 - a0 != 3 || n_ack1 - a1 != 3) begin
      errors++; $display("FAIL b2b_ack_count: got %0d/%0d expected 3", n_ack0 - a0, n_ack1 - a1);
    end
    checks++;
    if ({und0, und1, busy0, busy1} !== 4'b1100) begin
      errors++; $display("FAIL b2b_end: got und=%b%b busy=%b%b expected und=11 busy=00", und0, und1, busy0, busy1);
    end
  endtask

  task automatic test_dav_toggle();
    int n;
    int a;
    n = 0;
    do begin
      tick();
      n++;
    end while (!stb0 && n < 2 * DIV);
    checks++;
    if ({stb0, busy0, busy1} !== 3'b100) begin
      errors++; $display("FAIL toggle_sync: got stb=%b busy=%b%b expected stb=1 busy=00", stb0, busy0, busy1);
    end
    a = n_ack0 + n_ack1;
    tick(); drive(1'b1, 1'b1);
    tick(); drive(1'b1, 1'b0);
    tick(); tick();
    checks++;
    if ({stb0, stb1, bus0.ack, bus1.ack, busy0, busy1} !== 6'b110000 || n_ack0 + n_ack1 != a) begin
      errors++; $display("FAIL toggle_no_ack: got stb=%b%b ack=%b%b busy=%b%b acks=%0d expected 11/00/00 acks=%0d",
                         stb0, stb1, bus0.ack, bus1.ack, busy0, busy1, n_ack0 + n_ack1, a);
    end
    checks++;
    if ({dac0, dac1} !== {16'h8000, 16'h8000}) begin
      errors++; $display("FAIL toggle_idle_dac: got %h/%h expected 8000", dac0, dac1);
    end
    drive(1'b1, 1'b1);
    repeat (3) tick();
    checks++;
    if (n_ack0 + n_ack1 != a) begin
      errors++; $display("FAIL toggle_between_strobes: got %0d acks expected %0d", n_ack0 + n_ack1, a);
    end
    tick();
    checks++;
    if ({bus0.ack, bus1.ack, stb0, stb1, busy0, busy1} !== 6'b111111) begin
      errors++; $display("FAIL toggle_accept: got ack=%b%b stb=%b%b busy=%b%b expected all 1",
                         bus0.ack, bus1.ack, stb0, stb1, busy0, busy1);
    end
    drive(1'b1, 1'b0);
    step_samples(64);
    checks++;
    if ({und0, und1} !== 2'b11) begin
      errors++; $display("FAIL toggle_underrun: got %b%b expected 11", und0, und1);
    end
  endtask

  task automatic test_mid_bit_reset();
    int lat;
    drive(1'b1, 1'b1);
    wait_ack(2 * DIV, lat);
    drive(1'b1, 1'b0);
    step_samples(20);
    checks++;
    if ({dac0, dac1} !== {16'hDA82, 16'hDA82}) begin
      errors++; $display("FAIL midreset_k20: got %h/%h expected DA82", dac0, dac1);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({dac0, dac1} !== {16'h8000, 16'h8000} ||
        {busy0, busy1, bus0.ack, bus1.ack, stb0, stb1} !== 6'b0) begin
      errors++; $display("FAIL midreset_clear: got dac=%h/%h busy=%b%b ack=%b%b stb=%b%b expected 8000 and 0",
                         dac0, dac1, busy0, busy1, bus0.ack, bus1.ack, stb0, stb1);
    end
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b1);
    wait_ack(2 * DIV, lat);
    checks++;
    if ({bus0.ack, bus1.ack} !== 2'b11 || lat != DIV) begin
      errors++; $display("FAIL midreset_accept: got ack=%b%b after %0d cycles expected 11 after %0d",
                         bus0.ack, bus1.ack, lat, DIV);
    end
    drive(1'b0, 1'b0);
    step_samples(4);
    checks++;
    if ({dac0, dac1} !== {16'hDA82, 16'hDA82}) begin
      errors++; $display("FAIL midreset_k4: got %h/%h expected DA82", dac0, dac1);
    end
    step_samples(4);
    checks++;
    if ({dac0, dac1} !== {16'hFFFF, 16'hFFFF}) begin
      errors++; $display("FAIL midreset_k8: got %h/%h expected FFFF", dac0, dac1);
    end
    step_samples(56);
    checks++;
    if ({und0, und1, busy0, busy1} !== 4'b1100) begin
      errors++; $display("FAIL midreset_underrun: got und=%b%b busy=%b%b expected 11/00", und0, und1, busy0, busy1);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0);
    test_reset();
    test_single_bit(1'b0, 16'hDA82, 16'hFFFF, 16'h0001);
    test_single_bit(1'b1, 16'h257E, 16'h0001, 16'hFFFF);
    test_back_to_back();
    test_dav_toggle();
    test_mid_bit_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
